// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared types and default parameters for the pipelined carry-look-ahead
// adder/subtractor.
//   op_e        : operation select (OP_ADD = 0, OP_SUB = 1)
//   DEF_WIDTH   : default operand width
//   DEF_STAGES  : default pipeline depth (WIDTH must be a multiple of it)
// -----------------------------------------------------------------------------
package cla_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

endpackage : cla_pkg

// File: rtl/pipelined_cla_adder_if.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder_if
// Valid/ready stream bundle for the pipelined adder.
//   Input side  : in_valid, in_ready, a, b, cin, op
//   Output side : out_valid, out_ready, sum, cout, overflow
//   master : the producer/consumer around the adder (drives operands, out_ready)
//   slave  : the adder itself
// -----------------------------------------------------------------------------
interface pipelined_cla_adder_if
  import cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  op_e              op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );

endinterface : pipelined_cla_adder_if

// File: rtl/cla_block.sv
// -----------------------------------------------------------------------------
// cla_block
// Purely combinational CHUNK-bit carry-look-ahead adder.
//   i_a, i_b  : CHUNK-bit operands
//   i_ci      : carry into bit 0
//   o_s       : CHUNK-bit sum
//   o_co      : carry out of the MSB
//   o_co_msb  : carry into the MSB (used for signed overflow)
// -----------------------------------------------------------------------------
module cla_block #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_ci,
  output logic [CHUNK-1:0] o_s,
  output logic             o_co,
  output logic             o_co_msb
);

  logic [CHUNK-1:0] w_g;
  logic [CHUNK-1:0] w_p;
  logic [CHUNK:0]   w_c;   // w_c[i] = carry into bit i

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Each carry is built as a flat sum of products:
  //   c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]ci
  // so no carry depends on another computed carry.
  always_comb begin
    logic w_run;
    logic w_acc;
    w_c    = '0;
    w_run  = 1'b1;
    w_acc  = 1'b0;
    w_c[0] = i_ci;
    for (int i = 1; i <= CHUNK; i++) begin
      w_run = 1'b1;
      w_acc = 1'b0;
      for (int j = i - 1; j >= 0; j--) begin
        w_acc = w_acc | (w_g[j] & w_run);
        w_run = w_run & w_p[j];
      end
      w_c[i] = w_acc | (i_ci & w_run);
    end
  end

  assign o_s      = w_p ^ w_c[CHUNK-1:0];
  assign o_co     = w_c[CHUNK];
  assign o_co_msb = w_c[CHUNK-1];

endmodule : cla_block

// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
// Pipelined carry-look-ahead adder/subtractor with a valid/ready stream.
// The operand is cut into STAGES chunks of CHUNK bits; stage i adds chunk i
// and hands its carry to stage i+1 through a register.
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset (clears valid bits only)
//   bus  : slave side of pipelined_cla_adder_if
//          in_valid/in_ready/a/b/cin/op -> operand beat
//          out_valid/out_ready/sum/cout/overflow <- result beat
// WIDTH must be an exact multiple of STAGES.
// -----------------------------------------------------------------------------
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic                clk,
  input  logic                rst,
  pipelined_cla_adder_if.slave bus
);

  localparam int CHUNK = WIDTH / STAGES;

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  // Subtraction is a + ~b + !cin, which yields a - b - cin and a carry-out
  // that reads as "no borrow".
  assign w_b_eff   = (bus.op == OP_SUB) ? ~bus.b   : bus.b;
  assign w_cin_eff = (bus.op == OP_SUB) ? ~bus.cin : bus.cin;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      // Bits of a / effective b still waiting to be added after this stage.
      localparam int HI_W = WIDTH - (gi + 1) * CHUNK;

      logic [CHUNK-1:0]          w_a;
      logic [CHUNK-1:0]          w_b;
      logic [CHUNK-1:0]          w_s;
      logic                      w_ci;
      logic                      w_co;
      logic                      w_cmsb;
      logic                      w_vin;
      logic                      r_valid;
      logic                      r_carry;
      logic [(gi+1)*CHUNK-1:0]   r_sum;   // completed low chunks so far

      cla_block #(
        .CHUNK (CHUNK)
      ) u_cla (
        .i_a      (w_a),
        .i_b      (w_b),
        .i_ci     (w_ci),
        .o_s      (w_s),
        .o_co     (w_co),
        .o_co_msb (w_cmsb)
      );

      if (gi == 0) begin : g_src
        assign w_a   = bus.a[CHUNK-1:0];
        assign w_b   = w_b_eff[CHUNK-1:0];
        assign w_ci  = w_cin_eff;
        assign w_vin = bus.in_valid;

        always_ff @(posedge clk) begin
          if (w_adv) begin
            r_sum <= w_s;
          end
        end
      end else begin : g_src
        assign w_a   = g_stage[gi-1].g_hi.r_a_hi[CHUNK-1:0];
        assign w_b   = g_stage[gi-1].g_hi.r_b_hi[CHUNK-1:0];
        assign w_ci  = g_stage[gi-1].r_carry;
        assign w_vin = g_stage[gi-1].r_valid;

        always_ff @(posedge clk) begin
          if (w_adv) begin
            r_sum <= {w_s, g_stage[gi-1].r_sum};
          end
        end
      end

      // Valid bits are the only reset state; a stall freezes them too.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid <= 1'b0;
        end else if (w_adv) begin
          r_valid <= w_vin;
        end
      end

      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_carry <= w_co;
        end
      end

      if (HI_W > 0) begin : g_hi
        // Triangular delay line: the unused upper operand bits ride along
        // until their stage consumes the lowest chunk.
        logic [HI_W-1:0] w_a_up;
        logic [HI_W-1:0] w_b_up;
        logic [HI_W-1:0] r_a_hi;
        logic [HI_W-1:0] r_b_hi;
        logic            w_unused_cmsb;

        // Only the top chunk's MSB carry matters for overflow.
        assign w_unused_cmsb = w_cmsb;

        if (gi == 0) begin : g_up
          assign w_a_up = bus.a[WIDTH-1:CHUNK];
          assign w_b_up = w_b_eff[WIDTH-1:CHUNK];
        end else begin : g_up
          assign w_a_up = g_stage[gi-1].g_hi.r_a_hi[HI_W+CHUNK-1:CHUNK];
          assign w_b_up = g_stage[gi-1].g_hi.r_b_hi[HI_W+CHUNK-1:CHUNK];
        end

        always_ff @(posedge clk) begin
          if (w_adv) begin
            r_a_hi <= w_a_up;
            r_b_hi <= w_b_up;
          end
        end
      end else begin : g_last
        logic r_cmsb;

        always_ff @(posedge clk) begin
          if (w_adv) begin
            r_cmsb <= w_cmsb;
          end
        end
      end
    end
  endgenerate

  // The last stage registers are the output registers.
  assign bus.out_valid = g_stage[STAGES-1].r_valid;
  assign bus.sum       = g_stage[STAGES-1].r_sum;
  assign bus.cout      = g_stage[STAGES-1].r_carry;
  assign bus.overflow  = g_stage[STAGES-1].g_last.r_cmsb ^ g_stage[STAGES-1].r_carry;

  // Whole pipeline moves together; bubbles are kept rather than squeezed.
  assign w_adv        = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

endmodule : pipelined_cla_adder

// File: tb/tb_pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_cla_adder
// Self-checking bench for pipelined_cla_adder (WIDTH=16, STAGES=4): directed
// corner beats, backpressure, mid-flight reset and a randomized run scored
// against an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_pipelined_cla_adder;
  import cla_pkg::*;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;
  localparam int N_RAND = 10000;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipelined_cla_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_cla_adder #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  int    n_out = 0;
  logic  last_acc_in;
  beat_t q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for sum/cout and signed
  // for the overflow range test.
  function automatic beat_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic cin, input logic op);
    beat_t m;
    int ua, ub, ci, ur, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    ci = int'(cin);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (op) begin
      ur = ua - ub - ci;
      sr = sa - sb - ci;
      m.cout = (ur >= 0);
    end else begin
      ur = ua + ub + ci;
      sr = sa + sb + ci;
      m.cout = (ur >= (1 << WIDTH));
    end
    m.a   = a;
    m.b   = b;
    m.cin = cin;
    m.op  = op;
    m.sum = ur[WIDTH-1:0];
    m.ovf = (sr > (1 << (WIDTH-1)) - 1) || (sr < -(1 << (WIDTH-1)));
    return m;
  endfunction

  // One clock: resolve transfers shortly after inputs settle, then advance
  // to 1 ns past the next rising edge.
  task automatic tick();
    logic  acc_in;
    logic  acc_out;
    beat_t e;
    #1;
    acc_in  = bus.in_valid && bus.in_ready && !rst;
    acc_out = bus.out_valid && bus.out_ready && !rst;
    if (acc_out) begin
      if (q.size() == 0) begin
        check("spurious_out", 32'(bus.out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        n_out++;
        $display("txn %0d op=%0d a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b (exp %h %b %b)",
                 n_out, e.op, e.a, e.b, e.cin, bus.sum, bus.cout, bus.overflow,
                 e.sum, e.cout, e.ovf);
        check("sum", 32'(bus.sum), 32'(e.sum));
        check("cout", 32'(bus.cout), 32'(e.cout));
        check("ovf", 32'(bus.overflow), 32'(e.ovf));
      end
    end
    if (acc_in) begin
      q.push_back(model(bus.a, bus.b, bus.cin, bus.op));
    end
    last_acc_in = acc_in;
    @(posedge clk);
    if (rst) q.delete();
    #1;
  endtask

  task automatic new_beat();
    bus.in_valid = 1'b1;
    bus.a        = WIDTH'($urandom);
    bus.b        = WIDTH'($urandom);
    bus.cin      = 1'($urandom_range(0, 1));
    bus.op       = ($urandom_range(0, 1) != 0) ? OP_SUB : OP_ADD;
  endtask

  // Single beat into an idle pipeline; checks latency and literal results.
  task automatic send_and_check(input string tag, input op_e op, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic cin,
                                input logic [WIDTH-1:0] esum, input logic ecout,
                                input logic eovf);
    int n;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = cin;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check({tag, "_acc"}, 32'(last_acc_in), 32'd1);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(STAGES - 1));
    if (bus.out_valid) begin
      check({tag, "_sum"}, 32'(bus.sum), 32'(esum));
      check({tag, "_cout"}, 32'(bus.cout), 32'(ecout));
      check({tag, "_ovf"}, 32'(bus.overflow), 32'(eovf));
    end
    tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    int n0;
    int guard;

    // 1. reset with garbage on the inputs
    new_beat();
    bus.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // 2./3. directed corners
    send_and_check("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_and_check("add_ovf",  OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_and_check("sub_neg",  OP_SUB, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    send_and_check("sub_ovf",  OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    send_and_check("add_cin",  OP_ADD, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0);
    send_and_check("sub_bin",  OP_SUB, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0);

    // 4. backpressure: 6 back-to-back beats, out_ready low for 5 cycles
    n0 = n_out;
    sent = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (sent < 6) new_beat(); else bus.in_valid = 1'b0;
      tick();
      if (last_acc_in) sent++;
    end
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp_sent_stalled", 32'(sent), 32'd4);
    bus.out_ready = 1'b1;
    guard = 0;
    while ((sent < 6 || q.size() != 0) && guard < 40) begin
      if (sent < 6) new_beat(); else bus.in_valid = 1'b0;
      tick();
      if (last_acc_in) sent++;
      guard++;
    end
    bus.in_valid = 1'b0;
    check("bp_count", 32'(n_out - n0), 32'd6);
    check("bp_drain", 32'(q.size()), 32'd0);

    // 5. reset mid-flight flushes everything
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      new_beat();
      tick();
      check("flush_acc", 32'(last_acc_in), 32'd1);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    send_and_check("post_rst", OP_ADD, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) tick();
    check("flush_quiet", 32'(bus.out_valid), 32'd0);

    // 6. randomized stream with random backpressure
    sent = 0;
    guard = 0;
    while (sent < N_RAND && guard < 60000) begin
      if ($urandom_range(0, 3) != 0) new_beat(); else bus.in_valid = 1'b0;
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      if (last_acc_in) sent++;
      guard++;
    end
    check("rand_sent", 32'(sent), 32'(N_RAND));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    check("rand_drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipelined_cla_adder
